// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL supervisor and its surroundings.
interface pll_lock_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int RETRY_W = 2
) ();

    logic                  locked;
    logic                  restart;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  ready;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic [STATE_W-1:0]    state_o;

    // Supervisor side.
    modport master (
        input  locked, restart,
        output pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state_o
    );

    // PLL / system side.
    modport slave (
        output locked, restart,
        input  pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state_o
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage resynchronization of an asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification, retry/fault supervision on refclk.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20,
    parameter int RETRY_W             = 2
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_lock_supervisor_if.master  bus
);

    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic                  locked_s;
    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [RETRY_W-1:0]    retry, retry_nxt;
    logic [LOSS_CNT_W-1:0] loss, loss_nxt;
    logic                  cnt_clr;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.locked),
        .q     (locked_s)
    );

    // Next-state, retry and lock-loss bookkeeping; restart overrides everything.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        loss_nxt  = loss;
        cnt_clr   = 1'b0;
        if (bus.restart) begin
            state_nxt = PLL_RST;
            retry_nxt = '0;
            cnt_clr   = 1'b1;
        end else begin
            unique case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TMO_LAST) begin
                        if (retry == RETRY_MAX) begin
                            state_nxt = FAULT;
                        end else begin
                            retry_nxt = retry + RETRY_W'(1);
                            state_nxt = PLL_RST;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        if (loss != '1) loss_nxt = loss + LOSS_CNT_W'(1);
                        state_nxt = PLL_RST;
                    end
                end
                FAULT: ;
                default: state_nxt = PLL_RST;
            endcase
        end
        // Counter only runs in the timed states and idles at zero elsewhere.
        if (cnt_clr || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if (state == PLL_RST || state == WAIT_LOCK || state == STABLE) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end
    end

    // State registers and registered output decodes of the next state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            retry         <= '0;
            loss          <= '0;
            bus.pll_rst   <= 1'b1;
            bus.sys_rst_n <= 1'b0;
            bus.ready     <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry         <= retry_nxt;
            loss          <= loss_nxt;
            bus.pll_rst   <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            bus.sys_rst_n <= (state_nxt == RUN);
            bus.ready     <= (state_nxt == RUN);
            bus.fault     <= (state_nxt == FAULT);
        end
    end

    assign bus.retry_cnt     = retry;
    assign bus.lock_loss_cnt = loss;
    assign bus.state_o       = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with shortened timings.
module tb_pll_lock_supervisor;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   tests_run = 0;
    int   fails     = 0;
    int   edge_n    = 0;

    pll_lock_supervisor_if #(.RETRY_W(2)) ifc ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (20),
        .RETRY_W             (2)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (ifc)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic do_release();
        rst_n = 1'b0;
        ifc.locked = 1'b0;
        ifc.restart = 1'b0;
        tick();
        tick();
        @(negedge refclk);
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic pulse_restart();
        ifc.restart = 1'b1;
        tick();
        ifc.restart = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.locked = 1'b1;
        ifc.restart = 1'b0;
        tick();
        tick();
        tests_run++; if (ifc.state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", ifc.state_o); end
        tests_run++; if (ifc.pll_rst !== 1'b1 || ifc.sys_rst_n !== 1'b0 || ifc.ready !== 1'b0 || ifc.fault !== 1'b0)
            begin fails++; $display("FAIL reset_outputs: pll_rst=%b sys_rst_n=%b ready=%b fault=%b expected 1 0 0 0", ifc.pll_rst, ifc.sys_rst_n, ifc.ready, ifc.fault); end
        tests_run++; if (ifc.retry_cnt !== 2'd0 || ifc.lock_loss_cnt !== 8'd0)
            begin fails++; $display("FAIL reset_counts: retry=%0d loss=%0d expected 0 0", ifc.retry_cnt, ifc.lock_loss_cnt); end
    endtask

    task automatic test_bringup();
        do_release();
        run_to(3);
        tests_run++; if (ifc.pll_rst !== 1'b1 || ifc.state_o !== 3'd0) begin fails++; $display("FAIL bringup_pulse: pll_rst=%b state=%0d expected 1 0", ifc.pll_rst, ifc.state_o); end
        run_to(4);
        tests_run++; if (ifc.pll_rst !== 1'b0 || ifc.state_o !== 3'd1) begin fails++; $display("FAIL bringup_wait: pll_rst=%b state=%0d expected 0 1", ifc.pll_rst, ifc.state_o); end
        run_to(10);
        ifc.locked = 1'b1;
        run_to(12);
        tests_run++; if (ifc.state_o !== 3'd1) begin fails++; $display("FAIL bringup_sync_lat: state=%0d expected 1", ifc.state_o); end
        run_to(13);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL bringup_stable: state=%0d expected 2", ifc.state_o); end
        run_to(20);
        tests_run++; if (ifc.sys_rst_n !== 1'b0 || ifc.state_o !== 3'd2) begin fails++; $display("FAIL bringup_prerun: sys_rst_n=%b state=%0d expected 0 2", ifc.sys_rst_n, ifc.state_o); end
        run_to(21);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.sys_rst_n !== 1'b1 || ifc.ready !== 1'b1 || ifc.retry_cnt !== 2'd0)
            begin fails++; $display("FAIL bringup_run: state=%0d sys_rst_n=%b ready=%b retry=%0d expected 3 1 1 0", ifc.state_o, ifc.sys_rst_n, ifc.ready, ifc.retry_cnt); end
    endtask

    task automatic test_glitch();
        do_release();
        run_to(10);
        ifc.locked = 1'b1;
        run_to(13);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL glitch_stable: state=%0d expected 2", ifc.state_o); end
        run_to(15);
        ifc.locked = 1'b0;
        run_to(16);
        ifc.locked = 1'b1;
        run_to(17);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL glitch_hold: state=%0d expected 2", ifc.state_o); end
        run_to(18);
        tests_run++; if (ifc.state_o !== 3'd1 || ifc.retry_cnt !== 2'd0) begin fails++; $display("FAIL glitch_back: state=%0d retry=%0d expected 1 0", ifc.state_o, ifc.retry_cnt); end
        run_to(19);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL glitch_restable: state=%0d expected 2", ifc.state_o); end
        run_to(26);
        tests_run++; if (ifc.state_o !== 3'd2 || ifc.sys_rst_n !== 1'b0) begin fails++; $display("FAIL glitch_count_restart: state=%0d sys_rst_n=%b expected 2 0", ifc.state_o, ifc.sys_rst_n); end
        run_to(27);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.ready !== 1'b1) begin fails++; $display("FAIL glitch_run: state=%0d ready=%b expected 3 1", ifc.state_o, ifc.ready); end
    endtask

    task automatic test_timeout();
        do_release();
        run_to(35);
        tests_run++; if (ifc.state_o !== 3'd1 || ifc.retry_cnt !== 2'd0) begin fails++; $display("FAIL tmo_wait1: state=%0d retry=%0d expected 1 0", ifc.state_o, ifc.retry_cnt); end
        run_to(36);
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.retry_cnt !== 2'd1 || ifc.pll_rst !== 1'b1)
            begin fails++; $display("FAIL tmo_retry1: state=%0d retry=%0d pll_rst=%b expected 0 1 1", ifc.state_o, ifc.retry_cnt, ifc.pll_rst); end
        run_to(40);
        tests_run++; if (ifc.state_o !== 3'd1) begin fails++; $display("FAIL tmo_wait2: state=%0d expected 1", ifc.state_o); end
        run_to(72);
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.retry_cnt !== 2'd2) begin fails++; $display("FAIL tmo_retry2: state=%0d retry=%0d expected 0 2", ifc.state_o, ifc.retry_cnt); end
        run_to(107);
        tests_run++; if (ifc.state_o !== 3'd1 || ifc.fault !== 1'b0) begin fails++; $display("FAIL tmo_wait3: state=%0d fault=%b expected 1 0", ifc.state_o, ifc.fault); end
        run_to(108);
        tests_run++; if (ifc.state_o !== 3'd4 || ifc.fault !== 1'b1 || ifc.pll_rst !== 1'b1 || ifc.sys_rst_n !== 1'b0)
            begin fails++; $display("FAIL tmo_fault: state=%0d fault=%b pll_rst=%b sys_rst_n=%b expected 4 1 1 0", ifc.state_o, ifc.fault, ifc.pll_rst, ifc.sys_rst_n); end
        run_to(160);
        tests_run++; if (ifc.state_o !== 3'd4 || ifc.fault !== 1'b1) begin fails++; $display("FAIL tmo_fault_hold: state=%0d fault=%b expected 4 1", ifc.state_o, ifc.fault); end
    endtask

    task automatic test_restart_fault();
        pulse_restart();
        ifc.locked = 1'b1;
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.retry_cnt !== 2'd0 || ifc.fault !== 1'b0 || ifc.pll_rst !== 1'b1)
            begin fails++; $display("FAIL rst_fault_exit: state=%0d retry=%0d fault=%b pll_rst=%b expected 0 0 0 1", ifc.state_o, ifc.retry_cnt, ifc.fault, ifc.pll_rst); end
        run_to(5);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL rst_fault_stable: state=%0d expected 2", ifc.state_o); end
        run_to(13);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL rst_fault_run: state=%0d loss=%0d expected 3 0", ifc.state_o, ifc.lock_loss_cnt); end
    endtask

    task automatic test_loss_in_run();
        ifc.locked = 1'b0;
        edge_n = 0;
        run_to(2);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.sys_rst_n !== 1'b1) begin fails++; $display("FAIL loss_hold: state=%0d sys_rst_n=%b expected 3 1", ifc.state_o, ifc.sys_rst_n); end
        run_to(3);
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.sys_rst_n !== 1'b0 || ifc.ready !== 1'b0 || ifc.pll_rst !== 1'b1 || ifc.lock_loss_cnt !== 8'd1)
            begin fails++; $display("FAIL loss_drop: state=%0d sys_rst_n=%b ready=%b pll_rst=%b loss=%0d expected 0 0 0 1 1", ifc.state_o, ifc.sys_rst_n, ifc.ready, ifc.pll_rst, ifc.lock_loss_cnt); end
        ifc.locked = 1'b1;
        run_to(7);
        tests_run++; if (ifc.state_o !== 3'd1) begin fails++; $display("FAIL loss_wait: state=%0d expected 1", ifc.state_o); end
        run_to(8);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL loss_stable: state=%0d expected 2", ifc.state_o); end
        run_to(16);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.lock_loss_cnt !== 8'd1) begin fails++; $display("FAIL loss_rerun: state=%0d loss=%0d expected 3 1", ifc.state_o, ifc.lock_loss_cnt); end
    endtask

    task automatic test_restart_run();
        pulse_restart();
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.sys_rst_n !== 1'b0 || ifc.ready !== 1'b0 || ifc.lock_loss_cnt !== 8'd1 || ifc.retry_cnt !== 2'd0)
            begin fails++; $display("FAIL rst_run_exit: state=%0d sys_rst_n=%b ready=%b loss=%0d retry=%0d expected 0 0 0 1 0", ifc.state_o, ifc.sys_rst_n, ifc.ready, ifc.lock_loss_cnt, ifc.retry_cnt); end
        run_to(2);
        pulse_restart();
        run_to(3);
        tests_run++; if (ifc.state_o !== 3'd0) begin fails++; $display("FAIL rst_pulse_restart: state=%0d expected 0", ifc.state_o); end
        run_to(4);
        tests_run++; if (ifc.state_o !== 3'd1) begin fails++; $display("FAIL rst_pulse_wait: state=%0d expected 1", ifc.state_o); end
        run_to(13);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.ready !== 1'b1) begin fails++; $display("FAIL rst_pulse_run: state=%0d ready=%b expected 3 1", ifc.state_o, ifc.ready); end
    endtask

    task automatic test_async_reset();
        pulse_restart();
        run_to(6);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL arst_pre: state=%0d expected 2", ifc.state_o); end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++; if (ifc.state_o !== 3'd0 || ifc.pll_rst !== 1'b1 || ifc.sys_rst_n !== 1'b0 || ifc.ready !== 1'b0 || ifc.fault !== 1'b0)
            begin fails++; $display("FAIL arst_outputs: state=%0d pll_rst=%b sys_rst_n=%b ready=%b fault=%b expected 0 1 0 0 0", ifc.state_o, ifc.pll_rst, ifc.sys_rst_n, ifc.ready, ifc.fault); end
        tests_run++; if (ifc.lock_loss_cnt !== 8'd0 || ifc.retry_cnt !== 2'd0) begin fails++; $display("FAIL arst_counts: loss=%0d retry=%0d expected 0 0", ifc.lock_loss_cnt, ifc.retry_cnt); end
        tick();
        @(negedge refclk);
        rst_n = 1'b1;
        edge_n = 0;
        run_to(3);
        tests_run++; if (ifc.state_o !== 3'd0) begin fails++; $display("FAIL arst_seq_pulse: state=%0d expected 0", ifc.state_o); end
        run_to(4);
        tests_run++; if (ifc.state_o !== 3'd1) begin fails++; $display("FAIL arst_seq_wait: state=%0d expected 1", ifc.state_o); end
        run_to(5);
        tests_run++; if (ifc.state_o !== 3'd2) begin fails++; $display("FAIL arst_seq_stable: state=%0d expected 2", ifc.state_o); end
        run_to(13);
        tests_run++; if (ifc.state_o !== 3'd3 || ifc.sys_rst_n !== 1'b1) begin fails++; $display("FAIL arst_seq_run: state=%0d sys_rst_n=%b expected 3 1", ifc.state_o, ifc.sys_rst_n); end
    endtask

    initial begin
        ifc.locked = 1'b0;
        ifc.restart = 1'b0;
        test_reset();
        test_bringup();
        test_glitch();
        test_timeout();
        test_restart_fault();
        test_loss_in_run();
        test_restart_run();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
